// File: rtl/note_detector_pkg.sv
// Shared constants for the buzzer / note detector pair: base half-periods,
// octave codes, FSM state encoding and the reference-table helper.
// Latency: n/a (package). Backpressure: n/a.
package note_detector_pkg;

   // Width of the half-period counter and of every table entry.
   localparam int CNT_W = 21;

   // Octave codes, identical to the buzzer encoding.
   localparam logic [1:0] OCT_BASE = 2'b00;   // base half-period
   localparam logic [1:0] OCT_HALF = 2'b01;   // base >> 1 (one octave up)
   localparam logic [1:0] OCT_DBL  = 2'b10;   // base << 1 (one octave down)

   localparam logic [3:0] NOTE_FIRST = 4'd1;  // do
   localparam logic [3:0] NOTE_LAST  = 4'd7;  // si

   // Base half-periods in clock cycles, do..si.
   localparam logic [CNT_W-1:0] BASE_DO  = 21'd381680;
   localparam logic [CNT_W-1:0] BASE_RE  = 21'd340136;
   localparam logic [CNT_W-1:0] BASE_MI  = 21'd303030;
   localparam logic [CNT_W-1:0] BASE_FA  = 21'd285714;
   localparam logic [CNT_W-1:0] BASE_SOL = 21'd255102;
   localparam logic [CNT_W-1:0] BASE_LA  = 21'd227273;
   localparam logic [CNT_W-1:0] BASE_SI  = 21'd202429;

   typedef enum logic [1:0] {
      ST_WAIT   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_DECIDE = 2'd2
   } state_t;

   // A detected tone: note number plus octave code.
   typedef struct packed {
      logic [3:0] note;
      logic [1:0] octave;
   } tone_id_t;

   function automatic logic [CNT_W-1:0] base_hp(input logic [3:0] n);
      logic [CNT_W-1:0] b;
      case (n)
         4'd1:    b = BASE_DO;
         4'd2:    b = BASE_RE;
         4'd3:    b = BASE_MI;
         4'd4:    b = BASE_FA;
         4'd5:    b = BASE_SOL;
         4'd6:    b = BASE_LA;
         4'd7:    b = BASE_SI;
         default: b = '0;
      endcase
      return b;
   endfunction

   // Expected measured count for note n in octave oct. The +1 accounts for
   // the counter restarting at 1 on the edge cycle. 'scale' shrinks the
   // whole table (0 = real buzzer timing).
   function automatic logic [CNT_W-1:0] ref_hp(input logic [3:0]  n,
                                                input logic [1:0]  oct,
                                                input int unsigned scale);
      logic [CNT_W-1:0] b;
      b = base_hp(n) >> scale;
      case (oct)
         OCT_HALF: b = b >> 1;
         OCT_DBL:  b = b << 1;
         default:  b = b;
      endcase
      return b + 21'd1;
   endfunction

endpackage

// File: rtl/note_detector_edge_sync.sv
// Synchronizes the asynchronous tone input and flags either transition.
// Latency: edge_o rises 2 cycles after tone_i is first sampled. Backpressure: none.
// Ports: clk/rst (sync, active-high); tone_i async square wave; edge_o one-cycle pulse.
module tone_edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic tone_i,
   output logic edge_o
);

   logic meta_q;   // first synchronizer stage, may go metastable
   logic sync_q;   // second stage, safe to use
   logic prev_q;   // sync_q delayed one cycle for edge detection

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= tone_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   // Both inputs are flops, so the pulse is glitch-free.
   assign edge_o = sync_q ^ prev_q;

endmodule

// File: rtl/note_detector.sv
// Measures tone half-periods and names the note/octave once it is stable.
// Latency: outputs update 23 cycles after the qualifying edge pulse. Backpressure: none.
// Ports: clk/rst (sync, active-high); tone_in async square wave;
//        note/octave/note_valid detected tone; note_change one-cycle pulse on any change.
module note_detector
   import note_detector_pkg::*;
#(
   parameter int          STABLE_CNT  = 2,
   parameter int          TOL_SHIFT   = 6,
   parameter int          TIMEOUT     = 1048575,
   parameter int unsigned SCALE_SHIFT = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tone_in,
   output logic [3:0] note,
   output logic [1:0] octave,
   output logic       note_valid,
   output logic       note_change
);

   localparam int SW = $clog2(STABLE_CNT + 1);
   localparam logic [CNT_W-1:0] TO_MAX     = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] TO_PRE     = CNT_W'(TIMEOUT - 1);
   localparam logic [SW-1:0]    STREAK_MAX = SW'(STABLE_CNT);

   logic edge_pulse;

   tone_edge_sync u_edge_sync (
      .clk    (clk),
      .rst    (rst),
      .tone_i (tone_in),
      .edge_o (edge_pulse)
   );

   state_t           state_q,     state_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;
   logic             armed_q,     armed_d;
   logic [CNT_W-1:0] meas_q,      meas_d;
   logic [3:0]       srch_note_q, srch_note_d;
   logic [1:0]       srch_oct_q,  srch_oct_d;
   logic             found_q,     found_d;
   tone_id_t         hit_q,       hit_d;
   tone_id_t         cand_q,      cand_d;
   logic [SW-1:0]    streak_q,    streak_d;
   tone_id_t         out_q,       out_d;
   logic             valid_q,     valid_d;
   logic             change_q,    change_d;

   logic             timeout_hit;
   logic [CNT_W-1:0] cur_ref;
   logic [CNT_W-1:0] cur_tol;
   logic [CNT_W-1:0] cur_diff;
   logic             cur_hit;
   logic [SW-1:0]    streak_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_WAIT;
         cnt_q       <= '0;
         armed_q     <= 1'b0;
         meas_q      <= '0;
         srch_note_q <= '0;
         srch_oct_q  <= '0;
         found_q     <= 1'b0;
         hit_q       <= '0;
         cand_q      <= '0;
         streak_q    <= '0;
         out_q       <= '0;
         valid_q     <= 1'b0;
         change_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         armed_q     <= armed_d;
         meas_q      <= meas_d;
         srch_note_q <= srch_note_d;
         srch_oct_q  <= srch_oct_d;
         found_q     <= found_d;
         hit_q       <= hit_d;
         cand_q      <= cand_d;
         streak_q    <= streak_d;
         out_q       <= out_d;
         valid_q     <= valid_d;
         change_q    <= change_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      armed_d     = armed_q;
      meas_d      = meas_q;
      srch_note_d = srch_note_q;
      srch_oct_d  = srch_oct_q;
      found_d     = found_q;
      hit_d       = hit_q;
      cand_d      = cand_q;
      streak_d    = streak_q;
      out_d       = out_q;
      valid_d     = valid_q;
      change_d    = 1'b0;
      streak_n    = '0;

      // Table entry currently under test and its match window.
      cur_ref  = ref_hp(srch_note_q, srch_oct_q, SCALE_SHIFT);
      cur_tol  = cur_ref >> TOL_SHIFT;
      cur_diff = (meas_q >= cur_ref) ? (meas_q - cur_ref) : (cur_ref - meas_q);
      cur_hit  = (cur_diff <= cur_tol);

      // Half-period counter: restarts at 1 on the edge cycle so that the
      // value seen on the next edge equals the full half-period.
      if (edge_pulse) begin
         cnt_d = 21'd1;
      end else if (cnt_q != TO_MAX) begin
         cnt_d = cnt_q + 21'd1;
      end

      // Fires once, on the cycle the counter steps onto TIMEOUT; an edge in
      // the same cycle restarts the counter instead.
      timeout_hit = !edge_pulse && (cnt_q == TO_PRE);

      if (edge_pulse && (state_q != ST_WAIT)) begin
         // Edge during a search: the measurement in flight is abandoned and
         // the new edge only restarts the counter.
         state_d  = ST_WAIT;
         streak_d = '0;
      end else begin
         case (state_q)
            ST_WAIT: begin
               if (edge_pulse) begin
                  if (armed_q) begin
                     meas_d      = cnt_q;
                     srch_note_d = NOTE_FIRST;
                     srch_oct_d  = OCT_BASE;
                     found_d     = 1'b0;
                     state_d     = ST_SEARCH;
                  end else begin
                     // Reference edge: starts timing, nothing to measure yet.
                     armed_d = 1'b1;
                  end
               end
            end

            ST_SEARCH: begin
               // First match wins; the scan always runs all 21 entries so the
               // decision latency is fixed.
               if (cur_hit && !found_q) begin
                  found_d      = 1'b1;
                  hit_d.note   = srch_note_q;
                  hit_d.octave = srch_oct_q;
               end
               if (srch_note_q == NOTE_LAST) begin
                  srch_note_d = NOTE_FIRST;
                  if (srch_oct_q == OCT_DBL) begin
                     state_d = ST_DECIDE;
                  end else begin
                     srch_oct_d = srch_oct_q + 2'd1;
                  end
               end else begin
                  srch_note_d = srch_note_q + 4'd1;
               end
            end

            ST_DECIDE: begin
               state_d = ST_WAIT;
               if (found_q) begin
                  if (hit_q == cand_q) begin
                     streak_n = (streak_q == STREAK_MAX) ? streak_q : (streak_q + 1'b1);
                  end else begin
                     cand_d   = hit_q;
                     streak_n = SW'(1);
                  end
                  streak_d = streak_n;
                  // Only a genuinely new tone is published; re-confirming the
                  // current one stays silent.
                  if ((streak_n == STREAK_MAX) && (!valid_q || (hit_q != out_q))) begin
                     out_d    = hit_q;
                     valid_d  = 1'b1;
                     change_d = 1'b1;
                  end
               end else begin
                  streak_d = '0;
                  cand_d   = '0;
               end
            end

            default: state_d = ST_WAIT;
         endcase
      end

      if (timeout_hit) begin
         out_d    = '0;
         valid_d  = 1'b0;
         change_d = valid_q;
         streak_d = '0;
         cand_d   = '0;
         armed_d  = 1'b0;
         state_d  = ST_WAIT;
      end
   end

   assign note        = out_q.note;
   assign octave      = out_q.octave;
   assign note_valid  = valid_q;
   assign note_change = change_q;

endmodule

// File: doc/note_detector.md
NOTE_DETECTOR -- requirements
Module: note_detector

Interface
REQ-001 SHALL have parameter STABLE_CNT, default 2: number of consecutive identical matched half-periods required before the outputs update.
REQ-002 SHALL have parameter TOL_SHIFT, default 6: the match tolerance is ref >> TOL_SHIFT cycles.
REQ-003 SHALL have parameter TIMEOUT, default 1048575: the number of edge-free cycles that declares silence.
REQ-004 Port clk, input, 1: the single system clock; all logic is on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port tone_in, input, 1: square wave asynchronous to clk, in the buzzer output format.
REQ-007 Port note, output, 4: detected note, 1=do to 7=si; 0 means silence.
REQ-008 Port octave, output, 2: 01 means half-period base>>1, 10 means base<<1, 00 means base; same encoding as the buzzer.
REQ-009 Port note_valid, output, 1: high while a note is being detected.
REQ-010 Port note_change, output, 1: one-cycle pulse whenever any of note, octave or note_valid changes.

Function
REQ-011 SHALL pass tone_in through a 2-flop synchronizer, then a registered edge detector that pulses edge for one cycle on either transition.
REQ-012 SHALL count half-periods with a 21-bit counter: set to 1 on an edge cycle, +1 per cycle otherwise, saturating at TIMEOUT.
REQ-013 On an edge while armed=1 and state WAIT, SHALL latch the count into meas and enter SEARCH.
REQ-014 On an edge while armed=0, SHALL only set armed=1; the first edge after reset or timeout is a reference and is never measured.
REQ-015 The reference table SHALL hold 21 entries r = (base[n] shifted per octave) + 1, where base = 381680, 340136, 303030, 285714, 255102, 227273, 202429 for n = 1..7.
REQ-016 The FSM SHALL have states WAIT, SEARCH and DECIDE; SEARCH tests one entry per cycle for exactly 21 cycles, in order octave 00, 01, 10 and n = 1..7 within each octave.
REQ-017 An entry SHALL match when |meas - r| <= (r >> TOL_SHIFT); the first matching entry wins, and later entries are still stepped through but ignored.
REQ-018 In DECIDE, SHALL handle the streak as follows, then return to WAIT:
- match equal to the candidate: streak += 1, saturating at STABLE_CNT.
- match different from the candidate: load the new candidate, streak = 1.
- no match: streak = 0, candidate cleared, outputs unchanged.
REQ-019 When streak reaches STABLE_CNT and the candidate differs from the current outputs, SHALL register note, octave and note_valid=1 and pulse note_change; the outputs update on cycle E+23, where E is the edge-pulse cycle.
REQ-020 An edge arriving while in SEARCH or DECIDE SHALL restart the counter, be dropped as a measurement, and clear the streak.
REQ-021 When the counter reaches TIMEOUT, SHALL set note=0, octave=00, note_valid=0, streak=0 and armed=0; note_change pulses only if note_valid was 1.
REQ-022 If timeout and an edge occur in the same cycle, the edge SHALL win: the counter restarts and the timeout is not taken.
REQ-023 Re-detecting a note identical to the current output SHALL NOT pulse note_change.

Reset
REQ-024 While rst=1, SHALL set the FSM to WAIT, counter=0, armed=0, streak=0, candidate=0, meas=0, note=0, octave=00, note_valid=0, note_change=0 and both synchronizer flops=0.
REQ-025 rst asserted mid-SEARCH SHALL abandon the search; no output update SHALL follow the release of rst.

Structure
REQ-026 The shared package SHALL hold the seven base half-period constants, the octave codes (00, 01, 10) and the FSM state enum; the buzzer and this block SHALL use the same constants.
REQ-027 Synchronizer and edge detect SHALL be one sub-module, tone_edge_sync; the table and FSM SHALL stay in note_detector.

Verification
REQ-028 Bench SHALL cover:
- Square wave, half-period 381681 cycles, 4 edges: note=1, octave=00, note_valid=1 at 23 cycles after the 3rd edge pulse; one note_change pulse.
- Switch the wave to half-period 101215 (si, 01): after 2 new half-periods, note=7, octave=01, one note_change pulse.
- Half-periods alternating 381681 and 340137: streak never reaches 2, and outputs stay at reset values.
- Single half-period of 250000 (no match) inside a stable la (227274) stream: outputs hold, and la re-asserts without a note_change pulse.
- Stop toggling while a note is valid: TIMEOUT cycles after the last edge, note=0, note_valid=0, one note_change pulse; the next edge is not measured.
- rst pulsed 5 cycles after an edge during a stable tone: all outputs 0 and no update follows; detection restarts from the reference edge.
